// File: rtl/hog_pkg.sv
// Shared definitions for the HOG cell scheduler.
// Contents: default histogram geometry (BINS, BIN_W), pixel field widths (MAG_W, ANG_W),
// FSM state encoding and a clog2 helper used for counter and index widths.
package hog_pkg;

    localparam int unsigned BINS  = 9;
    localparam int unsigned BIN_W = 14;
    localparam int unsigned MAG_W = 14;
    localparam int unsigned ANG_W = 14;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCUM  = 3'd1;
    localparam logic [2:0] DRAIN  = 3'd2;
    localparam logic [2:0] OUTPUT = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_ACCUM  = ACCUM,
        ST_DRAIN  = DRAIN,
        ST_OUTPUT = OUTPUT,
        ST_CLEAR  = CLEAR
    } state_t;

    // Ceiling log2, never below 1 so a width derived from it is always legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/hog_cell_counter.sv
// Pixel, drain and cell counters for the HOG cell scheduler.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_pix_inc      count one accepted pixel (saturates at CELL_PIXELS)
//   i_pix_clr      clear the pixel count
//   i_drain_run    drain counter runs while high, held at 0 otherwise
//   i_cell_inc     advance the cell index (wraps NUM_CELLS-1 -> 0)
//   o_pix_full     pixel count == CELL_PIXELS
//   o_pix_last     pixel count == CELL_PIXELS-1
//   o_drain_done   drain counter at its final cycle (DRAIN_CYC-1)
//   o_cell_idx     current cell index
module hog_cell_counter
    import hog_pkg::*;
#(
    parameter int unsigned CELL_PIXELS = 64,
    parameter int unsigned NUM_CELLS   = 16,
    parameter int unsigned DRAIN_CYC   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_pix_inc,
    input  logic                        i_pix_clr,
    input  logic                        i_drain_run,
    input  logic                        i_cell_inc,
    output logic                        o_pix_full,
    output logic                        o_pix_last,
    output logic                        o_drain_done,
    output logic [clog2(NUM_CELLS)-1:0] o_cell_idx
);

    localparam int unsigned PIX_W = clog2(CELL_PIXELS + 1);
    localparam int unsigned DRN_W = clog2(DRAIN_CYC);
    localparam int unsigned IDX_W = clog2(NUM_CELLS);

    logic [PIX_W-1:0] r_pix_cnt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [IDX_W-1:0] r_cell_idx;

    assign o_pix_full   = (r_pix_cnt == PIX_W'(CELL_PIXELS));
    assign o_pix_last   = (r_pix_cnt == PIX_W'(CELL_PIXELS - 1));
    assign o_drain_done = (r_drain_cnt == DRN_W'(DRAIN_CYC - 1));
    assign o_cell_idx   = r_cell_idx;

    // Pixel count: saturating, cleared between cells.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt <= '0;
        end else if (i_pix_clr) begin
            r_pix_cnt <= '0;
        end else if (i_pix_inc && !o_pix_full) begin
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end
    end

    // Drain count: restarts from 0 on every entry to the drain window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (!i_drain_run) begin
            r_drain_cnt <= '0;
        end else if (!o_drain_done) begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
        end
    end

    // Cell index: advances on each delivered cell, wraps at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cell_idx <= '0;
        end else if (i_cell_inc) begin
            if (r_cell_idx == IDX_W'(NUM_CELLS - 1)) begin
                r_cell_idx <= '0;
            end else begin
                r_cell_idx <= r_cell_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/hog_cell_scheduler.sv
// Sequences the HOG orientation-histogram accumulator over a frame of cells: feeds
// CELL_PIXELS pixels per cell into the accumulator, waits a drain window, captures the
// packed bins, hands them downstream on valid/ready, then clears the accumulator.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_start              frame start pulse, honoured only in IDLE
//   pix_valid/pix_ready      pixel handshake (pix_ready is combinational from state/count)
//   pix_mag, pix_ang         pixel magnitude (ufix14_En7) and angle (sfix14_En1)
//   hist_en                  accumulator enable, low clears it
//   hist_mag, hist_ang       registered pixel to the accumulator, 0 when idle
//   hist_h                   packed accumulator bins, bin0 in LSBs
//   cell_valid/cell_ready    histogram handshake
//   cell_hist, cell_idx      captured histogram and its cell index
//   frame_done               pulse after the last cell of a frame is delivered
// Optional: define HOG_CELL_SUM_EN to add cell_sum, the registered sum of all bins.
module hog_cell_scheduler
    import hog_pkg::*;
#(
    parameter int unsigned CELL_PIXELS = 64,
    parameter int unsigned NUM_CELLS   = 16,
    parameter int unsigned BINS        = hog_pkg::BINS,
    parameter int unsigned BIN_W       = hog_pkg::BIN_W,
    parameter int unsigned DRAIN_CYC   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [MAG_W-1:0]            pix_mag,
    input  logic [ANG_W-1:0]            pix_ang,
    output logic                        hist_en,
    output logic [MAG_W-1:0]            hist_mag,
    output logic [ANG_W-1:0]            hist_ang,
    input  logic [BINS*BIN_W-1:0]       hist_h,
    output logic                        cell_valid,
    input  logic                        cell_ready,
    output logic [BINS*BIN_W-1:0]       cell_hist,
    output logic [clog2(NUM_CELLS)-1:0] cell_idx,
    output logic                        frame_done
`ifdef HOG_CELL_SUM_EN
    ,
    output logic [BIN_W+3:0]            cell_sum
`endif
);

    localparam int unsigned HIST_W = BINS * BIN_W;
    localparam int unsigned IDX_W  = clog2(NUM_CELLS);

    state_t              r_state;
    state_t              w_next;
    logic                r_hist_en;
    logic [MAG_W-1:0]    r_hist_mag;
    logic [ANG_W-1:0]    r_hist_ang;
    logic                r_cell_valid;
    logic [HIST_W-1:0]   r_cell_hist;
    logic                r_frame_done;

    logic                w_hist_en;
    logic                w_cell_valid;
    logic                w_frame_done;
    logic                w_capture;
    logic                w_pix_ready;
    logic                w_accept;
    logic                w_handshake;
    logic                w_pix_full;
    logic                w_pix_last;
    logic                w_drain_done;
    logic [IDX_W-1:0]    w_cell_idx;

    assign w_pix_ready = (r_state == ST_ACCUM) && !w_pix_full;
    assign w_accept    = pix_valid && w_pix_ready;
    assign w_handshake = r_cell_valid && cell_ready;

    assign pix_ready  = w_pix_ready;
    assign hist_en    = r_hist_en;
    assign hist_mag   = r_hist_mag;
    assign hist_ang   = r_hist_ang;
    assign cell_valid = r_cell_valid;
    assign cell_hist  = r_cell_hist;
    assign cell_idx   = w_cell_idx;
    assign frame_done = r_frame_done;

    hog_cell_counter #(
        .CELL_PIXELS (CELL_PIXELS),
        .NUM_CELLS   (NUM_CELLS),
        .DRAIN_CYC   (DRAIN_CYC)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .i_pix_inc    (w_accept),
        .i_pix_clr    (r_state == ST_CLEAR),
        .i_drain_run  (r_state == ST_DRAIN),
        .i_cell_inc   (w_handshake),
        .o_pix_full   (w_pix_full),
        .o_pix_last   (w_pix_last),
        .o_drain_done (w_drain_done),
        .o_cell_idx   (w_cell_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        w_next       = r_state;
        w_hist_en    = 1'b0;
        w_cell_valid = 1'b0;
        w_frame_done = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && w_pix_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_next    = ST_OUTPUT;
                    w_capture = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (w_handshake) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // The index already advanced at the handshake; 0 means the frame wrapped.
                if (w_cell_idx == '0) begin
                    w_next       = ST_IDLE;
                    w_frame_done = 1'b1;
                end else begin
                    w_next = ST_ACCUM;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        w_hist_en    = (w_next == ST_ACCUM) || (w_next == ST_DRAIN) || (w_next == ST_OUTPUT);
        w_cell_valid = (w_next == ST_OUTPUT);
    end

    // Output registers, aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist_en    <= 1'b0;
            r_hist_mag   <= '0;
            r_hist_ang   <= '0;
            r_cell_valid <= 1'b0;
            r_cell_hist  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_hist_en    <= w_hist_en;
            r_hist_mag   <= w_accept ? pix_mag : '0;
            r_hist_ang   <= w_accept ? pix_ang : '0;
            r_cell_valid <= w_cell_valid;
            r_frame_done <= w_frame_done;
            if (w_capture) begin
                r_cell_hist <= hist_h;
            end
        end
    end

`ifdef HOG_CELL_SUM_EN
    localparam int unsigned SUM_W = BIN_W + 4;

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] r_cell_sum;

    // Sum of all accumulator bins, captured alongside the histogram.
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < BINS; i++) begin
            w_sum = w_sum + SUM_W'(hist_h[i*BIN_W +: BIN_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cell_sum <= '0;
        end else if (w_capture) begin
            r_cell_sum <= w_sum;
        end
    end

    assign cell_sum = r_cell_sum;
`endif

endmodule
